// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: command sequencer for a 4-bit up/down load counter.
// Takes one command per valid/ready handshake. For each command it issues
// one load cycle, then STEPS count-enable pulses spaced CMD_DIV+1 cycles
// apart, then a one-cycle DONE. It also keeps a sticky flag that records
// whether the counter's carry-out was seen during the run.
// Optional feature: define CNT_SEQ_ABORT_EN to add an ABORT input that
// ends a sequence early.
module count_seq_ctrl #(
  parameter int STEP_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              CLK,
  input  logic              RST_,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_MODE,
  input  logic [3:0]        CMD_START,
  input  logic [STEP_W-1:0] CMD_STEPS,
  input  logic [DIV_W-1:0]  CMD_DIV,
  input  logic              CO_IN,
`ifdef CNT_SEQ_ABORT_EN
  input  logic              ABORT,
`endif
  output logic              CNT_CE,
  output logic              CNT_LD,
  output logic              CNT_M,
  output logic [3:0]        CNT_D,
  output logic              BUSY,
  output logic              DONE,
  output logic              WRAP_SEEN
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_lat_q, div_lat_d;
  logic [STEP_W-1:0] steps_lat_q, steps_lat_d;
  logic [DIV_W-1:0]  pre_q, pre_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              wrap_q, wrap_d;
  logic              ce_q, ce_d, ld_q, ld_d, m_q, m_d, busy_q, busy_d, done_q, done_d;
  logic [3:0]        d_q, d_d;
  logic              accept, abort_req;

  assign CMD_READY = (state_q == S_IDLE);
  assign accept    = CMD_VALID && CMD_READY;

`ifdef CNT_SEQ_ABORT_EN
  assign abort_req = ABORT;
`else
  assign abort_req = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: the last pulse is when steps_q==1 and the prescaler is at 0. An abort forces DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_LOAD;
      S_LOAD: state_d = (steps_lat_q == '0) ? S_DONE : S_RUN;
      S_RUN:  if (pre_q == '0 && steps_q == STEP_W'(1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_req && (state_q == S_LOAD || state_q == S_RUN)) state_d = S_DONE;
  end

  // Datapath: latch the command, run the prescaler and steps down-counters, track wrap.
  always_comb begin
    div_lat_d   = div_lat_q;
    steps_lat_d = steps_lat_q;
    pre_d       = pre_q;
    steps_d     = steps_q;
    wrap_d      = wrap_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        div_lat_d   = CMD_DIV;
        steps_lat_d = CMD_STEPS;
        wrap_d      = 1'b0;
      end
      S_LOAD: begin
        pre_d   = div_lat_q;
        steps_d = steps_lat_q;
      end
      S_RUN: begin
        if (CO_IN) wrap_d = 1'b1;
        if (pre_q == '0) begin
          pre_d = div_lat_q;
          if (steps_q != '0) steps_d = steps_q - STEP_W'(1);
        end else begin
          pre_d = pre_q - DIV_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs: registered values computed from the next state. A CE fires in any cycle where RUN's prescaler sits at 0.
  always_comb begin
    ce_d   = (state_d == S_LOAD) || (state_d == S_RUN && pre_d == '0);
    ld_d   = (state_d == S_LOAD);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    m_d    = m_q;
    d_d    = d_q;
    if (accept) begin
      m_d = CMD_MODE;
      d_d = CMD_START;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      div_lat_q   <= '0;
      steps_lat_q <= '0;
      pre_q       <= '0;
      steps_q     <= '0;
      wrap_q      <= 1'b0;
      ce_q        <= 1'b0;
      ld_q        <= 1'b0;
      m_q         <= 1'b0;
      d_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      div_lat_q   <= div_lat_d;
      steps_lat_q <= steps_lat_d;
      pre_q       <= pre_d;
      steps_q     <= steps_d;
      wrap_q      <= wrap_d;
      ce_q        <= ce_d;
      ld_q        <= ld_d;
      m_q         <= m_d;
      d_q         <= d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign CNT_CE    = ce_q;
  assign CNT_LD    = ld_q;
  assign CNT_M     = m_q;
  assign CNT_D     = d_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign WRAP_SEEN = wrap_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with an attached 4-bit up/down load counter model.
module tb_count_seq_ctrl;
  logic       CLK = 1'b0;
  logic       RST_ = 1'b0;
  logic       CMD_VALID = 1'b0;
  logic       CMD_MODE = 1'b0;
  logic [3:0] CMD_START = '0;
  logic [7:0] CMD_STEPS = '0;
  logic [7:0] CMD_DIV = '0;
  logic       CO_IN;
  logic       CMD_READY, CNT_CE, CNT_LD, CNT_M, BUSY, DONE, WRAP_SEEN;
  logic [3:0] CNT_D;
`ifdef CNT_SEQ_ABORT_EN
  logic       ABORT = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  count_seq_ctrl #(.STEP_W(8), .DIV_W(8)) dut (
    .CLK(CLK), .RST_(RST_), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_MODE(CMD_MODE), .CMD_START(CMD_START), .CMD_STEPS(CMD_STEPS), .CMD_DIV(CMD_DIV),
    .CO_IN(CO_IN),
`ifdef CNT_SEQ_ABORT_EN
    .ABORT(ABORT),
`endif
    .CNT_CE(CNT_CE), .CNT_LD(CNT_LD), .CNT_M(CNT_M), .CNT_D(CNT_D),
    .BUSY(BUSY), .DONE(DONE), .WRAP_SEEN(WRAP_SEEN)
  );

  always #5 CLK = ~CLK;

  // Counter model: load on CE&LD, otherwise count up/down on CE; CO at terminal count.
  logic [3:0] q;
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_)       q <= '0;
    else if (CNT_CE) q <= CNT_LD ? CNT_D : (CNT_M ? q - 4'd1 : q + 4'd1);
  end
  assign CO_IN = CNT_M ? (q == 4'd0) : (q == 4'd15);

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command for one edge (state must be IDLE); returns in the LOAD cycle.
  task automatic send(input logic m, input logic [3:0] s, input logic [7:0] st, input logic [7:0] dv);
    CMD_MODE = m; CMD_START = s; CMD_STEPS = st; CMD_DIV = dv; CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
  endtask

  // Step from LOAD until DONE (bounded). Cycle n is n cycles after the LOAD cycle.
  task automatic run_seq(input int maxc, output logic [31:0] mask, output int cnt,
                         output int first, output int done_at, output int rdy_busy);
    mask = '0; cnt = 0; first = -1; done_at = -1; rdy_busy = 0;
    for (int n = 1; n <= maxc; n++) begin
      tick();
      if (CNT_CE) begin
        if (n < 32) mask[n] = 1'b1;
        if (first < 0) first = n;
        cnt++;
      end
      if (CMD_READY) rdy_busy++;
      if (DONE) begin done_at = n; break; end
    end
  endtask

  logic [31:0] mask;
  int cnt, first, done_at, rdy_busy;

  initial begin
    // Reset state
    #1;
    chk("rst_ce", CNT_CE, 0); chk("rst_ld", CNT_LD, 0); chk("rst_m", CNT_M, 0);
    chk("rst_d", CNT_D, 0); chk("rst_busy", BUSY, 0); chk("rst_done", DONE, 0);
    chk("rst_wrap", WRAP_SEEN, 0); chk("rst_ready", CMD_READY, 1);
    #13 RST_ = 1'b1;
    tick(); tick();
    chk("idle_busy", BUSY, 0); chk("idle_ce", CNT_CE, 0); chk("idle_ready", CMD_READY, 1);

    // Up count: start=3 steps=4 div=2
    send(0, 4'd3, 8'd4, 8'd2);
    chk("t2_ld", CNT_LD, 1); chk("t2_ce", CNT_CE, 1); chk("t2_d", CNT_D, 3);
    chk("t2_m", CNT_M, 0); chk("t2_busy", BUSY, 1); chk("t2_ready", CMD_READY, 0);
    run_seq(20, mask, cnt, first, done_at, rdy_busy);
    chk("t2_ce_mask", mask, 32'h0000_1248); chk("t2_done_at", done_at, 13);
    chk("t2_done_ce", CNT_CE, 0); chk("t2_done_busy", BUSY, 1);
    chk("t2_q", q, 7); chk("t2_wrap", WRAP_SEEN, 0); chk("t2_rdy_busy", rdy_busy, 0);
    tick();
    chk("t2_idle_ready", CMD_READY, 1); chk("t2_idle_busy", BUSY, 0);
    chk("t2_idle_done", DONE, 0); chk("t2_hold_d", CNT_D, 3);

    // Down count through wrap: start=0 steps=16 div=0
    send(1, 4'd0, 8'd16, 8'd0);
    chk("t3_m", CNT_M, 1);
    run_seq(30, mask, cnt, first, done_at, rdy_busy);
    chk("t3_ce_mask", mask, 32'h0001_FFFE); chk("t3_done_at", done_at, 17);
    chk("t3_q", q, 0); chk("t3_wrap", WRAP_SEEN, 1);
    tick();
    chk("t3_wrap_sticky", WRAP_SEEN, 1); chk("t3_hold_m", CNT_M, 1);

    // steps=0: load only
    send(0, 4'd9, 8'd0, 8'd5);
    chk("t4_wrap_clr", WRAP_SEEN, 0); chk("t4_ld", CNT_LD, 1); chk("t4_d", CNT_D, 9);
    run_seq(10, mask, cnt, first, done_at, rdy_busy);
    chk("t4_ce_mask", mask, 0); chk("t4_done_at", done_at, 1); chk("t4_q", q, 9);
    tick();

    // Valid held through busy: A(start=5 steps=2 div=1), then B(down start=12 steps=1 div=0)
    CMD_MODE = 0; CMD_START = 4'd5; CMD_STEPS = 8'd2; CMD_DIV = 8'd1; CMD_VALID = 1'b1;
    tick();
    CMD_MODE = 1; CMD_START = 4'd12; CMD_STEPS = 8'd1; CMD_DIV = 8'd0;
    chk("t5_a_d", CNT_D, 5);
    run_seq(20, mask, cnt, first, done_at, rdy_busy);
    chk("t5_a_mask", mask, 32'h0000_0014); chk("t5_a_done_at", done_at, 5);
    chk("t5_rdy_busy", rdy_busy, 0); chk("t5_a_q", q, 7);
    tick();
    chk("t5_idle_ready", CMD_READY, 1); chk("t5_idle_ld", CNT_LD, 0); chk("t5_idle_d", CNT_D, 5);
    tick();
    CMD_VALID = 1'b0;
    chk("t5_b_ld", CNT_LD, 1); chk("t5_b_d", CNT_D, 12); chk("t5_b_m", CNT_M, 1);
    run_seq(10, mask, cnt, first, done_at, rdy_busy);
    chk("t5_b_mask", mask, 32'h0000_0002); chk("t5_b_done_at", done_at, 2); chk("t5_b_q", q, 11);
    tick();

    // Full-scale steps with back-to-back CE
    send(0, 4'd0, 8'd255, 8'd0);
    run_seq(300, mask, cnt, first, done_at, rdy_busy);
    chk("fs_steps_cnt", cnt, 255); chk("fs_steps_done", done_at, 256); chk("fs_steps_q", q, 15);
    tick();
    // Full-scale divisor, single step
    send(0, 4'd1, 8'd1, 8'd255);
    run_seq(300, mask, cnt, first, done_at, rdy_busy);
    chk("fs_div_first", first, 256); chk("fs_div_cnt", cnt, 1); chk("fs_div_done", done_at, 257);
    tick();

    // Async reset mid-RUN
    send(0, 4'd2, 8'd8, 8'd1);
    tick(); tick(); tick();
    chk("t6_busy_pre", BUSY, 1);
    #2 RST_ = 1'b0;
    #1;
    chk("t6_ce", CNT_CE, 0); chk("t6_ld", CNT_LD, 0); chk("t6_busy", BUSY, 0);
    chk("t6_done", DONE, 0); chk("t6_d", CNT_D, 0); chk("t6_wrap", WRAP_SEEN, 0);
    chk("t6_ready", CMD_READY, 1);
    @(negedge CLK) RST_ = 1'b1;
    tick();
    chk("t6_post_busy", BUSY, 0); chk("t6_post_ready", CMD_READY, 1);

`ifdef CNT_SEQ_ABORT_EN
    // Abort in RUN: steps=8 div=1, CE at 2,4; abort during cycle 5
    send(0, 4'd0, 8'd8, 8'd1);
    tick(); tick(); tick(); tick(); tick();
    chk("ab_ce5", CNT_CE, 0);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("ab_done", DONE, 1); chk("ab_ce", CNT_CE, 0); chk("ab_busy", BUSY, 1); chk("ab_q", q, 2);
    tick();
    chk("ab_idle_ready", CMD_READY, 1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("ab_idle_ign_done", DONE, 0); chk("ab_idle_ign_busy", BUSY, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
